// File: rtl/fetch_stage_pkg.sv
// Shared core definitions: fetch FSM states, the canonical NOP encoding
// and the control-flow opcodes used by fetch, decode and the branch checker.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] BRANCH = 7'd99;
    localparam logic [6:0] JALR   = 7'd103;
    localparam logic [6:0] JAL    = 7'd111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    function automatic logic is_ctrl_flow(input logic [6:0] opcode);
        return (opcode == BRANCH) || (opcode == JALR) || (opcode == JAL);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding slot for a response that lands while
// decode is stalled; clear wins over load.
module fetch_skid_buf
    import fetch_stage_pkg::*;
#(
    parameter int REG_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                clear,
    input  logic [REG_SIZE-1:0] load_pc,
    input  logic [31:0]         load_inst,
    output logic                valid,
    output logic [REG_SIZE-1:0] pc,
    output logic [31:0]         inst
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= NOP_INST;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC ownership, single-outstanding imem requests,
// redirect flush (including in-flight responses) and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  REG_SIZE = 32,
    parameter logic [REG_SIZE-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                br_taken,
    input  logic [REG_SIZE-1:0] br_target,
    input  logic                trap_req,
    input  logic [REG_SIZE-1:0] trap_pc,
    input  logic                stall,
    output logic                imem_req,
    output logic [REG_SIZE-1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    output logic [REG_SIZE-1:0] if_pc,
    output logic [31:0]         if_inst
);

    fetch_state_e        state;
    logic [REG_SIZE-1:0] pc;
    logic [REG_SIZE-1:0] req_pc;
    logic [REG_SIZE-1:0] target;
    logic                redirect;
    logic                resp;
    logic                skid_valid;
    logic                skid_load;
    logic                skid_clear;
    logic [REG_SIZE-1:0] skid_pc;
    logic [31:0]         skid_inst;

    assign redirect = trap_req | br_taken;
    assign target   = trap_req ? trap_pc : br_target;

    // Request is held off while in reset so the port shows its reset value.
    assign imem_req  = rst_n & (state == REQ) & ~redirect & ~skid_valid;
    assign imem_addr = pc;

    assign resp       = (state == WAIT) & imem_rvalid & ~redirect;
    assign skid_load  = resp & stall;
    assign skid_clear = redirect | (~stall & skid_valid);

    fetch_skid_buf #(
        .REG_SIZE (REG_SIZE)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_pc   (req_pc),
        .load_inst (imem_rdata),
        .valid     (skid_valid),
        .pc        (skid_pc),
        .inst      (skid_inst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            unique case (state)
                REQ: begin
                    if (redirect) begin
                        pc <= target;
                    end else if (!skid_valid) begin
                        req_pc <= pc;
                        pc     <= pc + REG_SIZE'(4);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= imem_rvalid ? REQ : DROP;
                    end else if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                DROP: begin
                    if (redirect) pc <= target;
                    // The stale response retires the drop no matter what.
                    if (imem_rvalid) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= NOP_INST;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (!stall) begin
            if (skid_valid) begin
                if_valid <= 1'b1;
                if_pc    <= skid_pc;
                if_inst  <= skid_inst;
            end else if (resp) begin
                if_valid <= 1'b1;
                if_pc    <= req_pc;
                if_inst  <= imem_rdata;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect
// traffic checked against a queue-based fetch model and scoreboard.
module tb_fetch_stage;
    import fetch_stage_pkg::NOP_INST;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int n_checks = 0;
    int n_fail = 0;

    fetch_stage #(
        .REG_SIZE (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap_req    (trap_req),
        .trap_pc     (trap_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model state: next fetch address and the memory's one slot.
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] mem_addr = '0;
    bit          mem_pending = 0;
    bit          mem_dead = 0;
    int          mem_cnt = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          prev_active = 0;
    bit          prev_load = 0;
    bit          prev_redirect = 0;
    logic        m_redir;
    logic [31:0] m_tgt;
    logic        m_exp_req;
    ent_t        m_push;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mem_pending = 0;
            mem_dead = 0;
            mem_cnt = 0;
            exp_pc = RESET_PC;
            prev_active = 0;
            prev_load = 0;
            prev_redirect = 0;
        end else begin
            m_redir = trap_req | br_taken;
            m_tgt = trap_req ? trap_pc : br_target;
            m_exp_req = !mem_pending && (q.size() == 0) && !m_redir;
            check("imem_req", 32'(imem_req), 32'(m_exp_req));
            if (imem_req) check("imem_addr", imem_addr, exp_pc);
            if (imem_rvalid && mem_pending) begin
                if (!mem_dead && !m_redir) begin
                    m_push.pc = mem_addr;
                    m_push.inst = imem_rdata;
                    q.push_back(m_push);
                end
                mem_pending = 0;
                mem_dead = 0;
            end
            if (m_redir) begin
                q.delete();
                if (mem_pending) mem_dead = 1;
                exp_pc = m_tgt;
            end
            if (imem_req) begin
                mem_pending = 1;
                mem_addr = exp_pc;
                mem_cnt = $urandom_range(lat_hi, lat_lo);
                exp_pc = exp_pc + 32'd4;
            end
            prev_load = !stall && !m_redir;
            prev_redirect = m_redir;
            prev_active = 1;
        end
    end

    // Instruction memory: answers the outstanding request after mem_cnt cycles.
    always @(posedge clk) begin
        #1;
        if (rst_n && mem_pending && mem_cnt > 0) mem_cnt--;
        if (rst_n && mem_pending && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = (mem_addr == 32'h0) ? 32'h0050_0093 : $urandom;
        end else begin
            imem_rvalid = 1'b0;
        end
    end

    logic        exp_valid = 1'b0;
    logic [31:0] exp_if_pc = '0;
    logic [31:0] exp_if_inst = NOP_INST;
    ent_t        mon_pop;

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_if_pc = '0;
            exp_if_inst = NOP_INST;
        end else if (prev_active) begin
            if (prev_redirect) begin
                exp_valid = 1'b0;
            end else if (prev_load) begin
                if (q.size() > 0) begin
                    mon_pop = q.pop_front();
                    exp_valid = 1'b1;
                    exp_if_pc = mon_pop.pc;
                    exp_if_inst = mon_pop.inst;
                end else begin
                    exp_valid = 1'b0;
                end
            end
            check("if_valid", 32'(if_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("if_pc", if_pc, exp_if_pc);
                check("if_inst", if_inst, exp_if_inst);
            end
            check("skid_depth", (q.size() <= 1) ? 32'd1 : 32'd0, 32'd1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        trap_req = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        stall = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // First fetch after reset with a 1-cycle memory
        lat_lo = 1;
        lat_hi = 1;
        do_reset();
        #1;
        check("t1_req0", 32'(imem_req), 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        cyc();
        cyc();
        #1;
        check("t1_valid", 32'(if_valid), 32'd1);
        check("t1_pc", if_pc, 32'h0);
        check("t1_inst", if_inst, 32'h0050_0093);
        check("t1_req4", 32'(imem_req), 32'd1);
        check("t1_addr4", imem_addr, 32'h4);

        // Branch while waiting; late response dropped
        lat_lo = 2;
        lat_hi = 2;
        cyc();
        br_taken = 1'b1;
        br_target = 32'h100;
        cyc();
        #1;
        check("t2_flush", 32'(if_valid), 32'd0);
        cyc();
        #1;
        check("t2_req", 32'(imem_req), 32'd1);
        check("t2_addr", imem_addr, 32'h100);
        lat_lo = 1;
        lat_hi = 1;

        // Trap and branch together: trap target wins
        cyc();
        trap_req = 1'b1;
        trap_pc = 32'h80;
        br_taken = 1'b1;
        br_target = 32'h200;
        cyc();
        #1;
        check("t3_req", 32'(imem_req), 32'd1);
        check("t3_addr", imem_addr, 32'h80);
        check("t3_flush", 32'(if_valid), 32'd0);

        // Stall for three cycles while the response for 0x8 lands in the skid
        cyc();
        br_taken = 1'b1;
        br_target = 32'h4;
        cyc();
        #1;
        check("t4_addr4", imem_addr, 32'h4);
        cyc();
        cyc();
        #1;
        check("t4_pc4", if_pc, 32'h4);
        check("t4_addr8", imem_addr, 32'h8);
        stall = 1'b1;
        cyc();
        cyc();
        #1;
        check("t4_noreq", 32'(imem_req), 32'd0);
        check("t4_hold_v", 32'(if_valid), 32'd1);
        check("t4_hold_pc", if_pc, 32'h4);
        cyc();
        stall = 1'b0;
        #1;
        check("t4_noreq2", 32'(imem_req), 32'd0);
        cyc();
        #1;
        check("t4_rel_v", 32'(if_valid), 32'd1);
        check("t4_rel_pc", if_pc, 32'h8);
        check("t4_req_c", 32'(imem_req), 32'd1);
        check("t4_addr_c", imem_addr, 32'hC);

        // Redirect while stalled with a full skid
        stall = 1'b1;
        cyc();
        cyc();
        br_taken = 1'b1;
        br_target = 32'h40;
        cyc();
        #1;
        check("t5_flush", 32'(if_valid), 32'd0);
        check("t5_req", 32'(imem_req), 32'd1);
        check("t5_addr", imem_addr, 32'h40);
        stall = 1'b0;

        // PC wrap-around, then reset in the middle of a wait
        cyc();
        trap_req = 1'b1;
        trap_pc = 32'hFFFF_FFFC;
        cyc();
        #1;
        check("t6_top", imem_addr, 32'hFFFF_FFFC);
        cyc();
        cyc();
        #1;
        check("t6_wrap_req", 32'(imem_req), 32'd1);
        check("t6_wrap", imem_addr, 32'h0);
        check("t6_top_pc", if_pc, 32'hFFFF_FFFC);
        lat_lo = 2;
        lat_hi = 2;
        cyc();
        rst_n = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, NOP_INST);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Randomized traffic
        lat_lo = 1;
        lat_hi = 3;
        for (int i = 0; i < 1500; i++) begin
            cyc();
            stall = ($urandom % 4) == 0;
            if (($urandom % 10) == 0) begin
                br_taken = 1'b1;
                br_target = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            end
            if (($urandom % 20) == 0) begin
                trap_req = 1'b1;
                trap_pc = $urandom;
            end
            if (i == 700) begin
                rst_n = 1'b0;
                cyc();
                cyc();
                rst_n = 1'b1;
            end
        end

        stall = 1'b0;
        repeat (10) cyc();
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
